window_accum: RTL and testbench
===============================

Name: window_accum

Overview:
Parametrised windowed accumulator. Each valid sample contributes one of four operands: data1, data1+data2, data2, or zero. After N_SAMPLES valid samples the block outputs the window total with a one-cycle valid pulse and a window overflow flag, then restarts. Adds a valid qualifier, window length, wrap/saturate mode, sticky per-window overflow and synchronous clear, and generalises widths. Sits between the input operand sources and downstream result capture.

Parameters:
NB_INPUT, 3, width of each unsigned input operand (>=1)
NB_ACC, 8, accumulator/result width (>= NB_INPUT+1)
N_SAMPLES, 4, valid samples per window (>=1); counter width is a derived localparam, clog2(N_SAMPLES) with a minimum of 1

Ports:
clock  input  1  single clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_data1  input  NB_INPUT  unsigned operand 1
i_data2  input  NB_INPUT  unsigned operand 2
i_sel  input  2  operand select: 00 data1, 01 data1+data2, 10 data2, 11 zero
i_valid  input  1  sample qualifier
i_clear  input  1  synchronous window abort
i_mode  input  1  0 = wrap, 1 = saturate
o_data  output  NB_ACC  last completed window total
o_valid  output  1  one-cycle pulse when o_data updates
o_overflow  output  1  overflow flag for the window in o_data
o_count  output  clog2(N_SAMPLES) min 1  valid samples taken in the current window

Behaviour:
- Reset (i_reset=0, asynchronous): acc, count, window_ovf, o_data, o_valid, o_overflow all 0 immediately. The block resumes on the first rising edge after deassertion.
- Operand: data1 and data2 are zero-extended. The pre-add is NB_INPUT+1 bits wide, so there is no loss. The operand is zero-extended to NB_ACC+1 bits.
- On a rising edge with i_valid=1 and i_clear=0, compute sum = acc + operand (NB_ACC+1 bits). carry = sum[NB_ACC].
- If carry=0: next_acc = sum[NB_ACC-1:0].
- If carry=1 and i_mode=0: next_acc = sum[NB_ACC-1:0].
- If carry=1 and i_mode=1: next_acc = all ones.
- If carry=1: window_ovf is set. It stays set until the window ends.
- Saturate mode holds at max. Further carries keep window_ovf=1.
- i_mode is applied per sample. A change mid-window affects only subsequent samples.
- If count < N_SAMPLES-1: acc <= next_acc and count increments.
- If count == N_SAMPLES-1 (last sample of the window):
  - o_data <= next_acc
  - o_overflow <= window_ovf OR carry
  - o_valid <= 1 for exactly one cycle
  - acc, count, window_ovf <= 0
- Latency: o_valid and the new o_data are visible in the cycle after the edge that sampled the last sample.
- Back-to-back windows need no bubble: continuous valid samples give one pulse every N_SAMPLES cycles.
- i_valid=0: no state change except o_valid returning to 0.
- i_clear=1: acc, count, window_ovf <= 0 and o_valid <= 0. o_data and o_overflow hold. i_clear has priority over i_valid, so a simultaneous sample is dropped.
- N_SAMPLES=1: every valid sample produces an o_valid pulse with o_data = operand (saturated or wrapped as above).
- o_data and o_overflow hold between pulses.

Decomposition:
- Package window_accum_pkg:
  - select encodings SEL_D1=2'b00, SEL_SUM=2'b01, SEL_D2=2'b10, SEL_ZERO=2'b11
  - mode encodings MODE_WRAP=1'b0, MODE_SAT=1'b1
- Sub-module accum_operand_mux (combinational): i_sel plus pre-adder, output NB_INPUT+1 bits.
- Accumulate, saturate, count and output registers stay in window_accum.

Test Plan:
- Reset: drive i_reset=0 asynchronously between edges mid-window -> o_data=0, o_valid=0, o_overflow=0, o_count=0 immediately, before the next edge.
- Sum operand, defaults: sel=01, data1=7, data2=7, four consecutive valid samples, wrap -> o_data=56, o_overflow=0, o_valid high exactly one cycle after the 4th edge.
- Gapped input: sel=00, data1=5, i_valid alternating 1/0 -> one pulse after the 4th valid sample with o_data=20. o_count steps 1,1,2,2,3,3,0.
- Overflow, NB_ACC=5: sel=01, 7+7 x4.
  - Wrap: o_data=24 (56 mod 32), o_overflow=1.
  - Saturate: o_data=31, o_overflow=1.
  - Next window, sel=00, data1=1 x4: o_data=4, o_overflow=0.
- Clear: two samples of data1=7 (sel=00), then i_clear=1 with i_valid=1 -> count=0, o_data unchanged. Then sel=10, data2=3 x4 -> o_data=12.
- Zero select plus continuous stream:
  - Eight consecutive valids with sel=11 -> two pulses, 4 cycles apart, o_data=0 each time.
  - Eight consecutive valids with sel=10, data2=1 -> two pulses, o_data=4 each time.

Source files
------------

// File: rtl/window_accum_pkg.sv
// window_accum_pkg: operand select and overflow mode encodings shared by the windowed accumulator
package window_accum_pkg;
    localparam logic [1:0] SEL_D1   = 2'b00;
    localparam logic [1:0] SEL_SUM  = 2'b01;
    localparam logic [1:0] SEL_D2   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    function automatic int cnt_width(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/accum_operand_mux.sv
// accum_operand_mux: selects data1, data1+data2, data2 or zero as a lossless NB_INPUT+1 bit operand
module accum_operand_mux
    import window_accum_pkg::*;
#(
    parameter int NB_INPUT = 3
) (
    input  logic [NB_INPUT-1:0] i_data1,
    input  logic [NB_INPUT-1:0] i_data2,
    input  logic [1:0]          i_sel,
    output logic [NB_INPUT:0]   o_operand
);
    always_comb
        o_operand = i_sel == SEL_D1  ? {1'b0, i_data1} :
                    i_sel == SEL_SUM ? {1'b0, i_data1} + {1'b0, i_data2} :
                    i_sel == SEL_D2  ? {1'b0, i_data2} : '0;
endmodule

// File: rtl/window_accum.sv
// window_accum: sums N_SAMPLES valid operands per window, wrap or saturate on carry,
// and publishes the total with a one-cycle valid pulse and a sticky window overflow flag
module window_accum
    import window_accum_pkg::*;
#(
    parameter int NB_INPUT  = 3,
    parameter int NB_ACC    = 8,
    parameter int N_SAMPLES = 4
) (
    input  logic                                clock,
    input  logic                                i_reset,
    input  logic [NB_INPUT-1:0]                 i_data1,
    input  logic [NB_INPUT-1:0]                 i_data2,
    input  logic [1:0]                          i_sel,
    input  logic                                i_valid,
    input  logic                                i_clear,
    input  logic                                i_mode,
    output logic [NB_ACC-1:0]                   o_data,
    output logic                                o_valid,
    output logic                                o_overflow,
    output logic [cnt_width(N_SAMPLES)-1:0]     o_count
);
    localparam int NB_CNT = cnt_width(N_SAMPLES);

    logic [NB_ACC-1:0] acc;
    logic [NB_CNT-1:0] count;
    logic              window_ovf;
    logic [NB_INPUT:0] operand;
    logic [NB_ACC:0]   sum;
    logic              carry;
    logic [NB_ACC-1:0] next_acc;
    logic              last;

    accum_operand_mux #(.NB_INPUT(NB_INPUT)) u_mux (
        .i_data1  (i_data1),
        .i_data2  (i_data2),
        .i_sel    (i_sel),
        .o_operand(operand)
    );

    assign sum      = {1'b0, acc} + {{(NB_ACC-NB_INPUT){1'b0}}, operand};
    assign carry    = sum[NB_ACC];
    assign next_acc = (carry && i_mode == MODE_SAT) ? '1 : sum[NB_ACC-1:0];
    assign last     = count == NB_CNT'(N_SAMPLES - 1);
    assign o_count  = count;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            acc        <= '0;
            count      <= '0;
            window_ovf <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                acc        <= '0;
                count      <= '0;
                window_ovf <= 1'b0;
            end else if (i_valid && last) begin
                o_data     <= next_acc;
                o_overflow <= window_ovf | carry;
                o_valid    <= 1'b1;
                acc        <= '0;
                count      <= '0;
                window_ovf <= 1'b0;
            end else if (i_valid) begin
                acc        <= next_acc;
                count      <= count + NB_CNT'(1);
                window_ovf <= window_ovf | carry;
            end
        end
    end
endmodule

// File: tb/tb_window_accum.sv
// tb_window_accum: three configurations (default, NB_ACC=5, N_SAMPLES=1) driven in lockstep
// against a window-level model that keeps the sampled operands and totals them at window end
module tb_window_accum;
    import window_accum_pkg::*;

    logic       clock = 1'b0;
    logic       i_reset = 1'b0;
    logic [2:0] i_data1 = '0, i_data2 = '0;
    logic [1:0] i_sel = '0;
    logic       i_valid = 1'b0, i_clear = 1'b0, i_mode = 1'b0;

    logic [7:0] data0, data2;
    logic [4:0] data1;
    logic       valid0, valid1, valid2, ovf0, ovf1, ovf2;
    logic [1:0] count0, count1;
    logic [0:0] count2;

    always #5 clock = ~clock;

    window_accum dut0 (.clock(clock), .i_reset(i_reset), .i_data1(i_data1), .i_data2(i_data2),
        .i_sel(i_sel), .i_valid(i_valid), .i_clear(i_clear), .i_mode(i_mode),
        .o_data(data0), .o_valid(valid0), .o_overflow(ovf0), .o_count(count0));
    window_accum #(.NB_ACC(5)) dut1 (.clock(clock), .i_reset(i_reset), .i_data1(i_data1),
        .i_data2(i_data2), .i_sel(i_sel), .i_valid(i_valid), .i_clear(i_clear), .i_mode(i_mode),
        .o_data(data1), .o_valid(valid1), .o_overflow(ovf1), .o_count(count1));
    window_accum #(.N_SAMPLES(1)) dut2 (.clock(clock), .i_reset(i_reset), .i_data1(i_data1),
        .i_data2(i_data2), .i_sel(i_sel), .i_valid(i_valid), .i_clear(i_clear), .i_mode(i_mode),
        .o_data(data2), .o_valid(valid2), .o_overflow(ovf2), .o_count(count2));

    int n_checks = 0, n_fail = 0;
    int win_len[3] = '{4, 4, 1};
    int max_val[3] = '{255, 31, 255};
    int ops[3][4];
    int modes[3][4];
    int cnt[3] = '{0, 0, 0};
    int exp_data[3] = '{0, 0, 0};
    int exp_ovf[3] = '{0, 0, 0};
    int exp_valid[3] = '{0, 0, 0};

    task automatic chk(input string tag, input int k, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data", 0, int'(data0), exp_data[0]);
        chk("data", 1, int'(data1), exp_data[1]);
        chk("data", 2, int'(data2), exp_data[2]);
        chk("valid", 0, int'(valid0), exp_valid[0]);
        chk("valid", 1, int'(valid1), exp_valid[1]);
        chk("valid", 2, int'(valid2), exp_valid[2]);
        chk("ovf", 0, int'(ovf0), exp_ovf[0]);
        chk("ovf", 1, int'(ovf1), exp_ovf[1]);
        chk("ovf", 2, int'(ovf2), exp_ovf[2]);
        chk("count", 0, int'(count0), cnt[0]);
        chk("count", 1, int'(count1), cnt[1]);
        chk("count", 2, int'(count2), cnt[2]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0; exp_data[k] = 0; exp_ovf[k] = 0; exp_valid[k] = 0;
        end
    endtask

    // Window total recomputed from the list of sampled operands once the window is full
    task automatic model_edge();
        int op, total, t, ovf;
        op = i_sel == SEL_D1 ? int'(i_data1) : i_sel == SEL_SUM ? int'(i_data1) + int'(i_data2) :
             i_sel == SEL_D2 ? int'(i_data2) : 0;
        for (int k = 0; k < 3; k++) begin
            exp_valid[k] = 0;
            if (i_clear) cnt[k] = 0;
            else if (i_valid) begin
                ops[k][cnt[k]] = op;
                modes[k][cnt[k]] = int'(i_mode);
                cnt[k]++;
                if (cnt[k] == win_len[k]) begin
                    total = 0; ovf = 0;
                    for (int i = 0; i < win_len[k]; i++) begin
                        t = total + ops[k][i];
                        if (t > max_val[k]) begin
                            ovf = 1;
                            total = modes[k][i] == 1 ? max_val[k] : t - (max_val[k] + 1);
                        end else total = t;
                    end
                    exp_data[k] = total; exp_ovf[k] = ovf; exp_valid[k] = 1; cnt[k] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic c, input logic m, input logic [1:0] s,
                        input logic [2:0] a, input logic [2:0] b);
        i_valid = v; i_clear = c; i_mode = m; i_sel = s; i_data1 = a; i_data2 = b;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_all();
        @(negedge clock);
        i_reset = 1'b1;
        // 7+7 four times: 56 at 8 bits, wraps to 24 at 5 bits
        repeat (4) step(1, 0, MODE_WRAP, SEL_SUM, 7, 7);
        chk("sum56", 0, int'(data0), 56);
        chk("wrap24", 1, int'(data1), 24);
        chk("wrap_ovf", 1, int'(ovf1), 1);
        step(0, 0, MODE_WRAP, SEL_SUM, 7, 7);
        repeat (4) step(1, 0, MODE_SAT, SEL_SUM, 7, 7);
        chk("sat31", 1, int'(data1), 31);
        repeat (4) step(1, 0, MODE_SAT, SEL_D1, 1, 0);
        chk("ovf_clears", 1, int'(ovf1), 0);
        for (int i = 0; i < 8; i++) step(i % 2 == 0, 0, MODE_WRAP, SEL_D1, 5, 0);
        chk("gapped20", 0, int'(data0), 20);
        repeat (2) step(1, 0, MODE_WRAP, SEL_D1, 7, 0);
        step(1, 1, MODE_WRAP, SEL_D1, 7, 0);
        chk("clear_count", 0, int'(count0), 0);
        repeat (4) step(1, 0, MODE_WRAP, SEL_D2, 0, 3);
        chk("d2_12", 0, int'(data0), 12);
        repeat (8) step(1, 0, MODE_WRAP, SEL_ZERO, 7, 7);
        repeat (8) step(1, 0, MODE_WRAP, SEL_D2, 6, 1);
        // Asynchronous reset mid-window, observed before the next rising edge
        repeat (2) step(1, 0, MODE_WRAP, SEL_SUM, 5, 6);
        @(negedge clock);
        i_reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 i_reset = 1'b1;
        for (int i = 0; i < 400; i++)
            step($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, 1'($urandom),
                 2'($urandom), 3'($urandom), 3'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
